// File: rtl/step_dir_generator.sv
// Step/dir pulse source: turns one move command into timed step pulses with
// dir setup, minimum high/low widths, abort at safe points and position tracking.
module step_dir_generator #(
    parameter int DIR_SETUP_CYCLES = 4,
    parameter int STEP_HIGH_CYCLES = 4,
    parameter int COUNT_W          = 32,
    parameter int PERIOD_W         = 32
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                move_valid,
    output logic                move_ready,
    input  logic                move_dir,
    input  logic [COUNT_W-1:0]  move_steps,
    input  logic [PERIOD_W-1:0] move_period,
    input  logic                abort,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [COUNT_W-1:0]  steps_remaining,
    output logic [COUNT_W-1:0]  position
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        FINISH
    } state_t;

    localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] HIGH_LOAD  = PERIOD_W'(STEP_HIGH_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] HIGH_LEN   = PERIOD_W'(STEP_HIGH_CYCLES);

    state_t              r_state;
    state_t              w_stateNext;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] w_lowLen;
    logic                r_abortPend;
    logic                w_abortExit;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // An abort seen during HIGH is remembered so the pulse always finishes at full width.
    always_comb begin
        w_stateNext = r_state;
        w_abortExit = 1'b0;
        w_lowLen    = (r_period > HIGH_LEN) ? (r_period - HIGH_LEN) : PERIOD_W'(1);
        case (r_state)
            IDLE: begin
                if (move_valid) begin
                    w_stateNext = (move_steps != '0) ? SETUP : FINISH;
                end
            end
            SETUP: begin
                if (abort) begin
                    w_stateNext = FINISH;
                    w_abortExit = 1'b1;
                end else if (r_count == '0) begin
                    w_stateNext = HIGH;
                end
            end
            HIGH: begin
                if (r_count == '0) begin
                    if (abort || r_abortPend) begin
                        w_stateNext = FINISH;
                        w_abortExit = 1'b1;
                    end else begin
                        w_stateNext = LOW;
                    end
                end
            end
            LOW: begin
                if (abort) begin
                    w_stateNext = FINISH;
                    w_abortExit = 1'b1;
                end else if (r_count == '0) begin
                    w_stateNext = (steps_remaining != '0) ? HIGH : FINISH;
                end
            end
            FINISH: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            move_ready      <= 1'b1;
            step            <= 1'b0;
            dir             <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            steps_remaining <= '0;
            position        <= '0;
            r_period        <= '0;
            r_count         <= '0;
            r_abortPend     <= 1'b0;
        end else begin
            move_ready <= (w_stateNext == IDLE);
            step       <= (w_stateNext == HIGH);
            busy       <= (w_stateNext == SETUP) || (w_stateNext == HIGH) || (w_stateNext == LOW);
            done       <= (w_stateNext == FINISH);
            aborted    <= w_abortExit;

            if (r_state == IDLE) begin
                if (move_valid) begin
                    steps_remaining <= move_steps;
                    r_abortPend     <= 1'b0;
                    if (move_steps != '0) begin
                        dir      <= move_dir;
                        r_period <= move_period;
                        r_count  <= SETUP_LOAD;
                    end
                end
            end else begin
                if (r_state == HIGH && abort) begin
                    r_abortPend <= 1'b1;
                end
                // Position and remaining count move on the rising edge of each pulse.
                if (w_stateNext != r_state) begin
                    case (w_stateNext)
                        HIGH: begin
                            r_count         <= HIGH_LOAD;
                            position        <= dir ? (position + COUNT_W'(1)) : (position - COUNT_W'(1));
                            steps_remaining <= steps_remaining - COUNT_W'(1);
                        end
                        LOW: begin
                            r_count <= w_lowLen - PERIOD_W'(1);
                        end
                        default: begin
                        end
                    endcase
                end else if (r_count != '0) begin
                    r_count <= r_count - PERIOD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_step_dir_generator.sv
// Randomised bench for step_dir_generator: every cycle of each move is checked
// against a timeline computed arithmetically from the move parameters.
module tb_step_dir_generator;

    localparam int D = 4;
    localparam int H = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        move_valid;
    logic        move_ready;
    logic        move_dir;
    logic [31:0] move_steps;
    logic [31:0] move_period;
    logic        abort;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] steps_remaining;
    logic [31:0] position;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mPos;
    logic [31:0] mRem;
    logic        mDir;

    step_dir_generator #(
        .DIR_SETUP_CYCLES(D),
        .STEP_HIGH_CYCLES(H),
        .COUNT_W(32),
        .PERIOD_W(32)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .move_dir(move_dir),
        .move_steps(move_steps),
        .move_period(move_period),
        .abort(abort),
        .step(step),
        .dir(dir),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .steps_remaining(steps_remaining),
        .position(position)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int spacing(input int p);
        return H + ((p > H) ? (p - H) : 1);
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_step"}, step, 0);
        checkOutput({tag, "_dir"}, dir, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_aborted"}, aborted, 0);
        checkOutput({tag, "_rem"}, steps_remaining, 0);
        checkOutput({tag, "_pos"}, position, 0);
        checkOutput({tag, "_ready"}, move_ready, 1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            abort      = 1'($urandom_range(0, 1));
            move_valid = 1'b0;
            @(negedge CLK);
            checkOutput("idle_ready", move_ready, 1);
            checkOutput("idle_step", step, 0);
            checkOutput("idle_done", done, 0);
            checkOutput("idle_pos", position, mPos);
            @(posedge CLK);
            #1;
        end
        abort = 1'b0;
    endtask

    // Called just after a clock edge with the DUT idle. ra = abort cycle, rr = reset cycle (0 = none),
    // both counted from the first cycle after the accepting edge.
    task automatic applyStimulus(input logic d, input int n, input int p, input int ra, input int rr);
        int          s;
        int          f;
        int          ns;
        int          c;
        int          rise;
        bit          ab;
        bit          eStep;
        logic [31:0] pos0;
        logic        dir0;
        logic [31:0] ePos;
        pos0        = mPos;
        dir0        = mDir;
        move_valid  = 1'b1;
        move_dir    = d;
        move_steps  = 32'(n);
        move_period = 32'(p);
        abort       = 1'($urandom_range(0, 1));
        @(negedge CLK);
        checkOutput("pre_ready", move_ready, 1);
        checkOutput("pre_busy", busy, 0);
        checkOutput("pre_pos", position, mPos);
        checkOutput("pre_rem", steps_remaining, mRem);
        checkOutput("pre_dir", dir, mDir);
        @(posedge CLK);
        #1;

        s  = spacing(p);
        ab = 1'b0;
        if (n == 0) begin
            f  = 1;
            ns = 0;
        end else begin
            f  = D + n * s + 1;
            ns = n;
            if (ra >= 1 && ra <= D + n * s) begin
                ab = 1'b1;
                if (ra <= D) begin
                    f  = ra + 1;
                    ns = 0;
                end else begin
                    ns = (ra - D - 1) / s + 1;
                    f  = (((ra - D - 1) % s) < H) ? (D + (ns - 1) * s + H + 1) : (ra + 1);
                end
            end
        end

        for (int r = 1; r <= f; r++) begin
            abort       = (r == ra) || (r == f && $urandom_range(0, 1) == 1);
            move_valid  = 1'($urandom_range(0, 1));
            move_dir    = 1'($urandom_range(0, 1));
            move_steps  = $urandom;
            move_period = $urandom;
            reset       = (r == rr);
            @(negedge CLK);
            c     = 0;
            eStep = 1'b0;
            for (int i = 0; i < ns; i++) begin
                rise = D + 1 + i * s;
                if (rise <= r) c++;
                if (rise <= r && r <= rise + H - 1) eStep = 1'b1;
            end
            ePos = d ? (pos0 + 32'(c)) : (pos0 - 32'(c));
            checkOutput($sformatf("step@%0d", r), step, eStep);
            checkOutput($sformatf("dir@%0d", r), dir, (n > 0) ? d : dir0);
            checkOutput($sformatf("busy@%0d", r), busy, r < f);
            checkOutput($sformatf("done@%0d", r), done, r == f);
            checkOutput($sformatf("aborted@%0d", r), aborted, (r == f) && ab);
            checkOutput($sformatf("ready@%0d", r), move_ready, 0);
            checkOutput($sformatf("pos@%0d", r), position, ePos);
            checkOutput($sformatf("rem@%0d", r), steps_remaining, (n > 0) ? 32'(n - c) : 32'd0);
            @(posedge CLK);
            #1;
            if (r == rr) begin
                reset      = 1'b0;
                move_valid = 1'b0;
                abort      = 1'b0;
                @(negedge CLK);
                checkResetValues("midreset");
                @(posedge CLK);
                #1;
                mPos = '0;
                mDir = 1'b0;
                mRem = '0;
                return;
            end
        end
        move_valid = 1'b0;
        abort      = 1'b0;
        mPos = d ? (pos0 + 32'(ns)) : (pos0 - 32'(ns));
        mDir = (n > 0) ? d : dir0;
        mRem = (n > 0) ? 32'(n - ns) : 32'd0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        @(negedge CLK);
        checkResetValues("reset");
        mPos = '0;
        mDir = 1'b0;
        mRem = '0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n;
        int p;
        int ra;
        int rr;
        reset       = 1'b1;
        move_valid  = 1'b0;
        move_dir    = 1'b0;
        move_steps  = '0;
        move_period = '0;
        abort       = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        doReset();

        applyStimulus(1'b1, 3, 10, 0, 0);
        applyStimulus(1'b1, 0, 7, 0, 0);
        applyStimulus(1'b1, 4, 2, 0, 0);
        applyStimulus(1'b1, 5, 10, D + 1 + spacing(10) + 1, 0);
        checkOutput("abort_rem", steps_remaining, 3);
        idleCycles(2);

        doReset();
        applyStimulus(1'b0, 1, 3, 0, 0);
        checkOutput("wrap_pos", position, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 2, 6, 0, 0);
        applyStimulus(1'b1, 3, 8, 0, D + 2);

        repeat (60) begin
            n  = $urandom_range(0, 5);
            p  = $urandom_range(0, 12);
            ra = 0;
            rr = 0;
            if (n > 0 && $urandom_range(0, 1) == 1) ra = $urandom_range(1, D + n * spacing(p));
            if (n > 0 && $urandom_range(0, 7) == 0) rr = $urandom_range(1, D + n * spacing(p));
            applyStimulus(1'($urandom_range(0, 1)), n, p, ra, rr);
            if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
